// File: rtl/rf_wport_if.sv
// Write-port arbitration bundle between WB, the long-latency unit and the
// register file / ID forwarding path.
//   ws_rf_bus    : WB request {we, waddr[4:0], wdata[31:0]}
//   ws_hold      : WB must keep its bus and stage contents next cycle
//   lu_req/lu_waddr/lu_wdata : long-latency result, stable until lu_ack
//   lu_ack       : long-latency result accepted this cycle
//   rf_bus       : {rf_we, rf_waddr, rf_wdata} to register file / forwarding
//   rf_src       : 0 = WB, 1 = long-latency unit (0 when no write)
//   conflict_cnt : saturating count of cycles with both sides live
// master = requesters/consumers side, slave = arbiter side.
interface rf_wport_if;
  logic [37:0] ws_rf_bus;
  logic        ws_hold;
  logic        lu_req;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ack;
  logic [37:0] rf_bus;
  logic        rf_src;
  logic [15:0] conflict_cnt;

  modport master (
    output ws_rf_bus, lu_req, lu_waddr, lu_wdata,
    input  ws_hold, lu_ack, rf_bus, rf_src, conflict_cnt
  );

  modport slave (
    input  ws_rf_bus, lu_req, lu_waddr, lu_wdata,
    output ws_hold, lu_ack, rf_bus, rf_src, conflict_cnt
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. WB (side A) wins by default; the
// long-latency unit (side B) is forced through after losing STARVE_MAX
// consecutive cycles, stalling WB for that one cycle via ws_hold.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high; forces all grant outputs low
//   wp    : rf_wport_if.slave bundle (see interface file for signals)
// Grant outputs are combinational from the current inputs and the
// internal starvation counter; only the counters are registered.
module rf_wport_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  rf_wport_if.slave   wp
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic [31:0] ws_wdata;

  logic        a_live;
  logic        b_live;
  logic        b_zero;
  logic        force_b;
  logic        grant_b;

  logic [3:0]  starve_q, starve_d;
  logic [15:0] conflict_q, conflict_d;

  logic [37:0] rf_bus_d;
  logic        rf_src_d;
  logic        lu_ack_d;
  logic        ws_hold_d;

  assign {ws_we, ws_waddr, ws_wdata} = wp.ws_rf_bus;

  always_comb begin
    a_live    = ws_we && (ws_waddr != 5'd0);
    b_live    = wp.lu_req && (wp.lu_waddr != 5'd0);
    // Writes to r0 are dropped; a B request for r0 is simply retired.
    b_zero    = wp.lu_req && (wp.lu_waddr == 5'd0);
    force_b   = a_live && b_live && (starve_q == STARVE_LIM);
    grant_b   = b_live && (!a_live || force_b);

    rf_bus_d  = 38'b0;
    rf_src_d  = 1'b0;
    lu_ack_d  = 1'b0;
    ws_hold_d = 1'b0;
    if (!reset) begin
      lu_ack_d  = grant_b || b_zero;
      ws_hold_d = force_b;
      if (grant_b) begin
        rf_bus_d = {1'b1, wp.lu_waddr, wp.lu_wdata};
        rf_src_d = 1'b1;
      end else if (a_live) begin
        rf_bus_d = {1'b1, ws_waddr, ws_wdata};
      end
    end

    // Counter history restarts whenever B is retired or withdraws.
    starve_d = starve_q;
    if (!wp.lu_req || lu_ack_d) begin
      starve_d = 4'd0;
    end else if (b_live && !grant_b && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end

    conflict_d = conflict_q;
    if (a_live && b_live && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= 4'd0;
      conflict_q <= 16'd0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  assign wp.rf_bus       = rf_bus_d;
  assign wp.rf_src       = rf_src_d;
  assign wp.lu_ack       = lu_ack_d;
  assign wp.ws_hold      = ws_hold_d;
  assign wp.conflict_cnt = conflict_q;

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the pipeline WB stage and a long-latency unit (multi-cycle divider/multiplier writeback). Pipeline writes win by default. A starvation counter forces a grant to the long-latency unit after a bounded wait, holding WB for one cycle. The block sits between WB, the long-latency unit, and the register file / ID-stage forwarding, and drives the same 38-bit rf_bus format the ID stage already consumes.

## Interface
- STARVE_MAX, 4: number of consecutive lost arbitration cycles after which the long-latency unit wins; legal range 1..15.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- ws_rf_bus  in  38  WB request {we, waddr[4:0], wdata[31:0]}; a request exists when we=1.
- ws_hold  out  1  tells WB to keep ws_rf_bus and its stage contents unchanged next cycle (WB uses ready_go = !ws_hold).
- lu_req  in  1  long-latency unit has a result; held with stable data until lu_ack.
- lu_waddr  in  5  destination register.
- lu_wdata  in  32  result data.
- lu_ack  out  1  result accepted this cycle; unit may drop or change lu_req next cycle.
- rf_bus  out  38  {rf_we, rf_waddr, rf_wdata} to register file and ID forwarding.
- rf_src  out  1  source of the current write: 0 = WB, 1 = long-latency unit; 0 when rf_we=0.
- conflict_cnt  out  16  saturating count of cycles in which both sides held a live request.

## Operation
- Live A request: ws_rf_bus.we=1 and waddr!=0. Live B request: lu_req=1 and lu_waddr!=0.
- Zero-register rule: WB we=1 with waddr=0 is treated as no request and is never written. lu_req with lu_waddr=0 is acked immediately with rf_we=0, and does not touch the counter.
- Grant, combinational in the same cycle:
  - Only A live: A writes, rf_src=0.
  - Only B live: B writes, lu_ack=1, rf_src=1.
  - Both live, starve_cnt < STARVE_MAX: A writes; B waits.
  - Both live, starve_cnt == STARVE_MAX: B writes, lu_ack=1, ws_hold=1; A is retried next cycle with an unchanged bus.
  - Neither live: rf_we=0, rf_waddr=0, rf_wdata=0.
- starve_cnt, 4-bit internal register:
  - +1 when B is live and loses.
  - Cleared when B is acked or lu_req=0.
  - Never exceeds STARVE_MAX.
- The cycle after a forced B grant, A is guaranteed to win, because starve_cnt has been cleared.
- conflict_cnt: +1 each cycle both A and B are live; saturates at 16'hFFFF.
- Same waddr on both sides in one cycle: the normal grant applies. The loser's write still happens later, so the later write to that register comes from the loser.

## Timing
- Zero-cycle latency: rf_bus, lu_ack and ws_hold are combinational from the current inputs and starve_cnt.
- The register-file write commits at the following posedge.
- Reset (reset=1 sampled at posedge): starve_cnt=0, conflict_cnt=0.
- While reset=1, outputs are forced: rf_bus=38'b0, lu_ack=0, ws_hold=0, rf_src=0.
- Reset mid-wait discards arbitration history. A B request still asserted after reset is treated as fresh (starve_cnt=0).
- Worst-case B wait: STARVE_MAX cycles lost, then granted on cycle STARVE_MAX+1.
- ws_hold is high for at most one cycle in any two consecutive cycles.
- lu_ack is high only in a cycle where lu_req=1.

## Test plan
- A only: ws_rf_bus={1,5'd3,32'h1234}, lu_req=0 -> rf_bus={1,3,32'h1234}, rf_src=0, ws_hold=0, lu_ack=0.
- B only: lu_req=1, lu_waddr=7, lu_wdata=32'hDEAD, A we=0 -> rf_bus={1,7,32'hDEAD}, lu_ack=1 in the same cycle, rf_src=1.
- Starvation, STARVE_MAX=4: A writes r2 every cycle and B waits on r9.
  - Cycles 1-4: A wins; starve_cnt goes 1..4.
  - Cycle 5: B writes r9 with lu_ack=1 and ws_hold=1.
  - Cycle 6: A's held r2 write commits.
  - conflict_cnt=5.
- Zero register:
  - A {1,0,32'hFFFF} -> rf_we=0.
  - lu_req with lu_waddr=0 -> lu_ack=1, rf_we=0, starve_cnt unchanged.
- Reset mid-wait: at starve_cnt=3, assert reset for one cycle with lu_req held -> starve_cnt=0 and conflict_cnt=0 after reset; B granted only after 4 further lost cycles.
- Saturation: force 70000 conflict cycles -> conflict_cnt holds at 16'hFFFF.
